// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: op codes, FSM states and
// the per-op latency lookup.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    // Cycles from accept to response; illegal ops finish as fast as add.
    function automatic int unsigned op_latency(input logic [3:0]  op,
                                               input int unsigned mul_lat,
                                               input int unsigned div_lat);
        int unsigned lat;
        case (op)
            ALU_MUL: lat = mul_lat;
            ALU_DIV: lat = div_lat;
            default: lat = 1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational execute-stage ALU: add, sub, mul, div on unsigned operands.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    // Result truncated to WIDTH; divide by zero yields all ones.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_MUL: result = a * b;
            ALU_DIV: result = (b == '0) ? '1 : a / b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the
// requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant from current requests and the previous winner.
    always_comb begin
        grant    = '0;
        grant[0] = valid[0] & (~valid[1] | last_grant);
        grant[1] = valid[1] & (~valid[0] | ~last_grant);
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between the execute stage (id 0) and the aux/debug port
// (id 1). Operands are captured and held for the op latency so mul/div can be
// constrained as multi-cycle paths.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    logic [1:0]         grant;
    logic [WIDTH-1:0]   alu_result;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // ALU sees only captured operands, so its inputs are stable through EXEC.
    alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    assign req0_ready = (state_q == IDLE) & grant[0];
    assign req1_ready = (state_q == IDLE) & grant[1];
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

    // Next-state, operand capture, latency countdown and response formation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        result_d     = result_q;
        zero_d       = zero_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    op_d         = grant[1] ? req1_op : req0_op;
                    a_d          = grant[1] ? req1_a  : req0_a;
                    b_d          = grant[1] ? req1_b  : req0_b;
                    cnt_d        = CNT_W'(op_latency(op_d, MUL_LAT, DIV_LAT) - 1);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    if (!op_is_legal(op_q)) begin
                        result_d = '0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
                    end else if ((op_q == ALU_DIV) && (b_q == '0)) begin
                        result_d = '1;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        result_d = alu_result;
                        zero_d   = (alu_result == '0);
                        err_d    = 1'b0;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end
    end

endmodule
